// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store in flight, LATENCY-cycle response, RV32I lane handling.
// Build option: define DMEM_MISALIGN_ERR_EN to fault misaligned accesses instead of force-aligning them.
`timescale 1ns/1ps
module dmem_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int DEPTH = 1 << (ADDR_WIDTH - 2);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [2:0]            funct3_q, funct3_d;

    logic [31:0] mem [DEPTH];

    logic                  accept;
    logic                  enter_resp;
    logic                  acc_we;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [31:0]           acc_wdata;
    logic [2:0]            acc_f3;
    logic [ADDR_WIDTH-1:0] eff_addr;
    logic                  illegal;
    logic                  misal;
    logic                  fault;
    logic                  wr_en;
    logic [3:0]            wr_be;
    logic [31:0]           wr_lanes;
    logic [31:0]           rd_word;
    logic [ADDR_WIDTH-3:0] word_idx;
    logic                  unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH];

    function automatic logic [31:0] load_extract(input logic [31:0] w,
                                                 input logic [1:0]  lane,
                                                 input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lane[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] lane, input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 4'b0001 << lane;
            2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [31:0] wd, input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    assign req_ready = rst && (state_q == S_IDLE);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // With LATENCY==1 the commit happens on the accepting edge, so decode straight from the inputs.
    always_comb begin
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_f3    = funct3_q;
        if (state_q == S_IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr[ADDR_WIDTH-1:0];
            acc_wdata = req_wdata;
            acc_f3    = req_funct3;
        end
    end

    always_comb begin
        illegal  = acc_we ? (acc_f3 >= 3'b011)
                          : ((acc_f3 == 3'b011) || (acc_f3[2:1] == 2'b11));
        eff_addr = acc_addr;
        misal    = 1'b0;
`ifdef DMEM_MISALIGN_ERR_EN
        misal = ((acc_f3[1:0] == 2'b01) && acc_addr[0]) ||
                ((acc_f3[1:0] == 2'b10) && (acc_addr[1:0] != 2'b00));
`else
        if (acc_f3[1:0] == 2'b01) eff_addr[0] = 1'b0;
        if (acc_f3[1:0] == 2'b10) eff_addr[1:0] = 2'b00;
`endif
        fault = illegal || misal;
    end

    assign word_idx = eff_addr[ADDR_WIDTH-1:2];
    assign rd_word  = mem[word_idx];
    assign wr_be    = store_be(eff_addr[1:0], acc_f3);
    assign wr_lanes = store_lanes(acc_wdata, acc_f3);
    assign wr_en    = enter_resp && acc_we && !fault;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        funct3_d    = funct3_q;
        enter_resp  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    we_d     = req_we;
                    addr_d   = req_addr[ADDR_WIDTH-1:0];
                    wdata_d  = req_wdata;
                    funct3_d = req_funct3;
                    if (LATENCY == 1) begin
                        enter_resp = 1'b1;
                        state_d    = S_RESP;
                    end else begin
                        cnt_d   = LAT_M1;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    enter_resp = 1'b1;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Response is captured on the same edge as the store commit, so it stays frozen in RESP.
        if (enter_resp) begin
            rsp_err_d   = fault;
            rsp_rdata_d = (acc_we || fault) ? 32'd0 : load_extract(rd_word, eff_addr[1:0], acc_f3);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_ff @(posedge clk) begin
        we_q     <= we_d;
        addr_q   <= addr_d;
        wdata_q  <= wdata_d;
        funct3_q <= funct3_d;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en && wr_be[i]) mem[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (LATENCY=2): lanes, faults, backpressure, wrap and reset.
`timescale 1ns/1ps
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] r_data;
    logic        r_err;
    int          r_lat;
    logic [31:0] exp100;

    dmem_responder #(.ADDR_WIDTH(17), .LATENCY(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkint(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, output logic [31:0] rd, output logic er,
                        output int lat);
        int guard;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        rsp_ready  = 1'b0;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 40);
        rd = rsp_rdata;
        er = rsp_err;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk1("rsp_valid_after_hs", rsp_valid, 1'b0);
        chk1("req_ready_after_hs", req_ready, 1'b1);
    endtask

    initial begin
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_funct3 = 3'd0;
        rsp_ready  = 1'b0;

        // Reset
        repeat (3) @(negedge clk);
        chk1("req_ready_in_reset", req_ready, 1'b0);
        chk1("rsp_valid_in_reset", rsp_valid, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk1("rst_rsp_err", rsp_err, 1'b0);
        chk1("rst_req_ready", req_ready, 1'b1);
        chk32("rst_rsp_rdata", rsp_rdata, 32'd0);

        // Word write / read
        xact(1'b1, 32'h100, 32'hDEADBEEF, 3'b010, r_data, r_err, r_lat);
        chkint("sw_latency", r_lat, 2);
        chk1("sw_err", r_err, 1'b0);
        chk32("sw_rdata", r_data, 32'd0);
        xact(1'b0, 32'h100, 32'd0, 3'b010, r_data, r_err, r_lat);
        chkint("lw_latency", r_lat, 2);
        chk32("lw_100", r_data, 32'hDEADBEEF);
        chk1("lw_err", r_err, 1'b0);

        // Byte lanes
        xact(1'b1, 32'h101, 32'h0000_0080, 3'b000, r_data, r_err, r_lat);
        chk1("sb_err", r_err, 1'b0);
        xact(1'b0, 32'h101, 32'd0, 3'b000, r_data, r_err, r_lat);
        chk32("lb_101", r_data, 32'hFFFFFF80);
        xact(1'b0, 32'h101, 32'd0, 3'b100, r_data, r_err, r_lat);
        chk32("lbu_101", r_data, 32'h00000080);
        xact(1'b0, 32'h100, 32'd0, 3'b010, r_data, r_err, r_lat);
        chk32("lw_after_sb", r_data, 32'hDEAD80EF);
        exp100 = 32'hDEAD80EF;

        // Halfword lanes and sign
        xact(1'b1, 32'h200, 32'h11223344, 3'b010, r_data, r_err, r_lat);
        xact(1'b1, 32'h202, 32'h0000_8001, 3'b001, r_data, r_err, r_lat);
        chk1("sh_err", r_err, 1'b0);
        xact(1'b0, 32'h202, 32'd0, 3'b001, r_data, r_err, r_lat);
        chk32("lh_202", r_data, 32'hFFFF8001);
        xact(1'b0, 32'h202, 32'd0, 3'b101, r_data, r_err, r_lat);
        chk32("lhu_202", r_data, 32'h00008001);
        xact(1'b0, 32'h200, 32'd0, 3'b010, r_data, r_err, r_lat);
        chk32("lw_after_sh", r_data, 32'h80013344);

        // Backpressure with a competing request that must be ignored
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 32'h100;
        req_funct3 = 3'b010;
        rsp_ready  = 1'b0;
        @(posedge clk);
        #1;
        req_we    = 1'b1;
        req_wdata = 32'h55555555;
        r_lat = 0;
        do begin
            @(negedge clk);
            r_lat++;
        end while (!rsp_valid && r_lat < 40);
        chkint("bp_latency", r_lat, 2);
        for (int i = 0; i < 5; i++) begin
            chk1("bp_rsp_valid", rsp_valid, 1'b1);
            chk32("bp_rdata", rsp_rdata, exp100);
            chk1("bp_req_ready", req_ready, 1'b0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk1("bp_rsp_valid_after_hs", rsp_valid, 1'b0);
        xact(1'b0, 32'h100, 32'd0, 3'b010, r_data, r_err, r_lat);
        chk32("bp_ignored_store", r_data, exp100);

        // Misaligned word store
        xact(1'b1, 32'h102, 32'hCAFEF00D, 3'b010, r_data, r_err, r_lat);
        chkint("mis_sw_latency", r_lat, 2);
        chk32("mis_sw_rdata", r_data, 32'd0);
`ifdef DMEM_MISALIGN_ERR_EN
        chk1("mis_sw_err", r_err, 1'b1);
`else
        chk1("mis_sw_err", r_err, 1'b0);
        exp100 = 32'hCAFEF00D;
`endif
        xact(1'b0, 32'h100, 32'd0, 3'b010, r_data, r_err, r_lat);
        chk32("lw_after_mis_sw", r_data, exp100);

        // Misaligned halfword load
        xact(1'b0, 32'h203, 32'd0, 3'b001, r_data, r_err, r_lat);
`ifdef DMEM_MISALIGN_ERR_EN
        chk1("mis_lh_err", r_err, 1'b1);
        chk32("mis_lh_rdata", r_data, 32'd0);
`else
        chk1("mis_lh_err", r_err, 1'b0);
        chk32("mis_lh_rdata", r_data, 32'hFFFF8001);
`endif

        // Illegal funct3
        xact(1'b1, 32'h100, 32'h0, 3'b011, r_data, r_err, r_lat);
        chk1("ill_store_err", r_err, 1'b1);
        chkint("ill_store_latency", r_lat, 2);
        xact(1'b0, 32'h100, 32'd0, 3'b011, r_data, r_err, r_lat);
        chk1("ill_load011_err", r_err, 1'b1);
        chk32("ill_load011_rdata", r_data, 32'd0);
        xact(1'b0, 32'h100, 32'd0, 3'b111, r_data, r_err, r_lat);
        chk1("ill_load111_err", r_err, 1'b1);
        chk32("ill_load111_rdata", r_data, 32'd0);
        xact(1'b0, 32'h100, 32'd0, 3'b010, r_data, r_err, r_lat);
        chk32("lw_after_ill_store", r_data, exp100);

        // Upper address bits alias
        xact(1'b0, 32'h0002_0100, 32'd0, 3'b010, r_data, r_err, r_lat);
        chk32("wrap_lw", r_data, exp100);
        chk1("wrap_err", r_err, 1'b0);

        // Reset during WAIT of a store
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 32'h100;
        req_wdata  = 32'h12345678;
        req_funct3 = 3'b010;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk1("midrst_rsp_valid", rsp_valid, 1'b0);
        chk1("midrst_req_ready", req_ready, 1'b0);
        repeat (2) @(negedge clk);
        chk1("midrst_rsp_valid_hold", rsp_valid, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk1("midrst_rel_req_ready", req_ready, 1'b1);
        chk1("midrst_rel_rsp_valid", rsp_valid, 1'b0);
        xact(1'b0, 32'h100, 32'd0, 3'b010, r_data, r_err, r_lat);
        chk32("midrst_no_write", r_data, exp100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
